// File: rtl/csd_pkg.sv
// rtl/csd_pkg.sv - shared FSM and shape types for the colour/shape detector
package csd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FRAME = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SHAPE_NONE     = 2'd0,
        SHAPE_SQUARE   = 2'd1,
        SHAPE_TRIANGLE = 2'd2,
        SHAPE_CIRCLE   = 2'd3
    } shape_t;

endpackage

// File: rtl/csd_row_tracker.sv
// rtl/csd_row_tracker.sv - per-row run tracking and row-to-row width trend counters
module csd_row_tracker #(
    parameter int W_W       = 12,
    parameter int ERRX_MAX  = 2,
    parameter int ERRY_MAX  = 3,
    parameter int ROW_MIN   = 4,
    parameter int WIDTH_TOL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           pix_valid,
    input  logic           interesting,
    input  logic           row_end,
    output logic [W_W-1:0] wider_cnt,
    output logic [W_W-1:0] narrower_cnt,
    output logic [W_W-1:0] equal_cnt,
    output logic [W_W-1:0] rows_int
);

    localparam logic signed [W_W:0] TOL_S = (W_W+1)'(WIDTH_TOL);

    logic [W_W-1:0]        width;
    logic [W_W-1:0]        prev;
    logic [W_W-1:0]        errx;
    logic [W_W-1:0]        erry;
    logic signed [W_W:0]   width_s;
    logic signed [W_W:0]   lo_s;
    logic signed [W_W:0]   hi_s;
    logic                  row_hit;
    logic                  obj_open;

    // One extra sign bit keeps prev-TOL from wrapping when prev is small.
    always_comb begin
        width_s  = signed'({1'b0, width});
        lo_s     = signed'({1'b0, prev}) - TOL_S;
        hi_s     = signed'({1'b0, prev}) + TOL_S;
        row_hit  = (width >= W_W'(ROW_MIN));
        obj_open = (erry < W_W'(ERRY_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width        <= '0;
            prev         <= '0;
            errx         <= '0;
            erry         <= '0;
            wider_cnt    <= '0;
            narrower_cnt <= '0;
            equal_cnt    <= '0;
            rows_int     <= '0;
        end else if (clear) begin
            width        <= '0;
            prev         <= '0;
            errx         <= '0;
            erry         <= '0;
            wider_cnt    <= '0;
            narrower_cnt <= '0;
            equal_cnt    <= '0;
            rows_int     <= '0;
        end else if (row_end) begin
            width <= '0;
            errx  <= '0;
            if (obj_open) begin
                if (row_hit) begin
                    prev <= width;
                    erry <= '0;
                    if (rows_int != '1) rows_int <= rows_int + 1'b1;
                    if (rows_int != '0) begin
                        if (width_s < lo_s) begin
                            if (narrower_cnt != '1) narrower_cnt <= narrower_cnt + 1'b1;
                        end else if (width_s > hi_s) begin
                            if (wider_cnt != '1) wider_cnt <= wider_cnt + 1'b1;
                        end else begin
                            if (equal_cnt != '1) equal_cnt <= equal_cnt + 1'b1;
                        end
                    end
                end else if (rows_int != '0) begin
                    erry <= erry + 1'b1;
                end
            end
        end else if (pix_valid && (errx < W_W'(ERRX_MAX))) begin
            // errx reaching ERRX_MAX freezes the run until the row ends.
            if (interesting) begin
                if (width != '1) width <= width + 1'b1;
                errx <= '0;
            end else if (width != '0) begin
                errx <= errx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_shape_detector.sv
// rtl/color_shape_detector.sv - OV7670 RGB444 frame analyser: colour counts, row trend, shape verdict
// Optional pixel window enabled by defining CSD_ROI_EN.
module color_shape_detector
    import csd_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int W_W       = 12,
    parameter int COLOR_TH  = 12,
    parameter int ERRX_MAX  = 2,
    parameter int ERRY_MAX  = 3,
    parameter int ROW_MIN   = 4,
    parameter int WIDTH_TOL = 1
) (
    input  logic             CAM_pclk,
    input  logic             CAM_reset,
    input  logic             start,
    input  logic             CAM_vsync,
    input  logic             CAM_href,
    input  logic [7:0]       CAM_px_data,
`ifdef CSD_ROI_EN
    input  logic [W_W-1:0]   roi_x0,
    input  logic [W_W-1:0]   roi_x1,
    input  logic [W_W-1:0]   roi_y0,
    input  logic [W_W-1:0]   roi_y1,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] none_cnt,
    output logic [W_W-1:0]   wider_cnt,
    output logic [W_W-1:0]   narrower_cnt,
    output logic [W_W-1:0]   equal_cnt,
    output logic [W_W-1:0]   rows_int,
    output logic [1:0]       shape
);

    state_t         state;
    state_t         state_nxt;
    shape_t         shape_r;
    shape_t         verdict;
    logic           vsync_q;
    logic           href_q;
    logic           phase;
    logic [3:0]     r_lat;
    logic           vsync_rise;
    logic           href_rise;
    logic           href_fall;
    logic           in_frame;
    logic           start_acc;
    logic           byte1;
    logic           r_str;
    logic           g_str;
    logic           b_str;
    logic           interesting;
    logic           pix_in_roi;
    logic           row_in_roi;
    logic           pix_valid;
    logic           row_end;
    logic [W_W+1:0] slope2;
    logic [W_W+1:0] equal_ext;

    always_comb begin
        vsync_rise  = CAM_vsync & ~vsync_q;
        href_rise   = CAM_href & ~href_q;
        href_fall   = ~CAM_href & href_q;
        in_frame    = (state == ST_FRAME);
        // A DONE-state start is only taken once the verdict has been posted.
        start_acc   = start & ((state == ST_IDLE) | ((state == ST_DONE) & done));
        byte1       = in_frame & CAM_href & ~href_rise & phase;
        r_str       = int'(r_lat) > COLOR_TH;
        g_str       = int'(CAM_px_data[7:4]) > COLOR_TH;
        b_str       = int'(CAM_px_data[3:0]) > COLOR_TH;
        interesting = r_str | g_str | b_str;
        pix_valid   = byte1 & pix_in_roi;
        row_end     = in_frame & href_fall & row_in_roi;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_acc)  state_nxt = ST_ARM;
            ST_ARM:   if (vsync_rise) state_nxt = ST_FRAME;
            ST_FRAME: if (vsync_rise) state_nxt = ST_DONE;
            ST_DONE:  if (start_acc)  state_nxt = ST_ARM;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        slope2    = {({1'b0, wider_cnt} + {1'b0, narrower_cnt}), 1'b0};
        equal_ext = {2'b00, equal_cnt};
        if (rows_int == '0)
            verdict = SHAPE_NONE;
        else if (equal_ext >= slope2)
            verdict = SHAPE_SQUARE;
        else if ((wider_cnt != '0) && (narrower_cnt != '0))
            verdict = SHAPE_CIRCLE;
        else
            verdict = SHAPE_TRIANGLE;
    end

    always_ff @(posedge CAM_pclk or posedge CAM_reset) begin
        if (CAM_reset) begin
            state     <= ST_IDLE;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            phase     <= 1'b0;
            r_lat     <= '0;
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
            none_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shape_r   <= SHAPE_NONE;
        end else begin
            state   <= state_nxt;
            vsync_q <= CAM_vsync;
            href_q  <= CAM_href;
            if (!CAM_href) begin
                phase <= 1'b0;
            end else if (href_rise || !phase) begin
                phase <= 1'b1;
                r_lat <= CAM_px_data[3:0];
            end else begin
                phase <= 1'b0;
            end

            if (start_acc) begin
                red_cnt   <= '0;
                green_cnt <= '0;
                blue_cnt  <= '0;
                none_cnt  <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                shape_r   <= SHAPE_NONE;
            end else begin
                if (pix_valid) begin
                    if (r_str && (red_cnt != '1))        red_cnt   <= red_cnt + 1'b1;
                    if (g_str && (green_cnt != '1))      green_cnt <= green_cnt + 1'b1;
                    if (b_str && (blue_cnt != '1))       blue_cnt  <= blue_cnt + 1'b1;
                    if (!interesting && (none_cnt != '1)) none_cnt <= none_cnt + 1'b1;
                end
                // The cycle after entering DONE, so a row closed by the same edge is counted.
                if ((state == ST_DONE) && busy) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    shape_r <= verdict;
                end
            end
        end
    end

    assign shape = shape_r;

`ifdef CSD_ROI_EN
    logic [W_W-1:0] x_cnt;
    logic [W_W-1:0] y_cnt;

    always_ff @(posedge CAM_pclk or posedge CAM_reset) begin
        if (CAM_reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (!CAM_href)
                x_cnt <= '0;
            else if (byte1 && (x_cnt != '1))
                x_cnt <= x_cnt + 1'b1;
            if (start_acc)
                y_cnt <= '0;
            else if (in_frame && href_fall && (y_cnt != '1))
                y_cnt <= y_cnt + 1'b1;
        end
    end

    assign row_in_roi = (y_cnt >= roi_y0) && (y_cnt <= roi_y1);
    assign pix_in_roi = row_in_roi && (x_cnt >= roi_x0) && (x_cnt <= roi_x1);
`else
    assign row_in_roi = 1'b1;
    assign pix_in_roi = 1'b1;
`endif

    csd_row_tracker #(
        .W_W       (W_W),
        .ERRX_MAX  (ERRX_MAX),
        .ERRY_MAX  (ERRY_MAX),
        .ROW_MIN   (ROW_MIN),
        .WIDTH_TOL (WIDTH_TOL)
    ) u_row_tracker (
        .clk          (CAM_pclk),
        .rst          (CAM_reset),
        .clear        (start_acc),
        .pix_valid    (pix_valid),
        .interesting  (interesting),
        .row_end      (row_end),
        .wider_cnt    (wider_cnt),
        .narrower_cnt (narrower_cnt),
        .equal_cnt    (equal_cnt),
        .rows_int     (rows_int)
    );

endmodule

// File: tb/tb_color_shape_detector.sv
// tb/tb_color_shape_detector.sv - directed-vector bench for color_shape_detector
module tb_color_shape_detector;

    localparam int CNT_W = 20;
    localparam int W_W   = 12;

    logic             CAM_pclk = 1'b0;
    logic             CAM_reset;
    logic             start;
    logic             CAM_vsync;
    logic             CAM_href;
    logic [7:0]       CAM_px_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] blue_cnt;
    logic [CNT_W-1:0] none_cnt;
    logic [W_W-1:0]   wider_cnt;
    logic [W_W-1:0]   narrower_cnt;
    logic [W_W-1:0]   equal_cnt;
    logic [W_W-1:0]   rows_int;
    logic [1:0]       shape;

    int total = 0;
    int bad   = 0;

    always #5 CAM_pclk = ~CAM_pclk;

    color_shape_detector dut (
        .CAM_pclk     (CAM_pclk),
        .CAM_reset    (CAM_reset),
        .start        (start),
        .CAM_vsync    (CAM_vsync),
        .CAM_href     (CAM_href),
        .CAM_px_data  (CAM_px_data),
`ifdef CSD_ROI_EN
        .roi_x0       ({W_W{1'b0}}),
        .roi_x1       ({W_W{1'b1}}),
        .roi_y0       ({W_W{1'b0}}),
        .roi_y1       ({W_W{1'b1}}),
`endif
        .busy         (busy),
        .done         (done),
        .red_cnt      (red_cnt),
        .green_cnt    (green_cnt),
        .blue_cnt     (blue_cnt),
        .none_cnt     (none_cnt),
        .wider_cnt    (wider_cnt),
        .narrower_cnt (narrower_cnt),
        .equal_cnt    (equal_cnt),
        .rows_int     (rows_int),
        .shape        (shape)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CAM_pclk);
        #1;
    endtask

    function automatic logic [31:0] run_mask(input int w, input int off);
        logic [31:0] one;
        one = 32'd1;
        return ((one << w) - one) << off;
    endfunction

    task automatic send_row(input logic [31:0] mask, input int n, input logic [11:0] col);
        logic [11:0] p;
        for (int i = 0; i < n; i++) begin
            p = mask[i] ? col : 12'h000;
            CAM_href    = 1'b1;
            CAM_px_data = {4'h0, p[11:8]};
            tick;
            CAM_px_data = p[7:0];
            tick;
        end
        CAM_href    = 1'b0;
        CAM_px_data = 8'h00;
        tick;
        tick;
    endtask

    task automatic begin_frame(input string t);
        start = 1'b1;
        tick;
        start = 1'b0;
        check({t, "_start_busy"}, 32'(busy), 32'd1);
        check({t, "_start_done"}, 32'(done), 32'd0);
        check({t, "_start_clr"}, 32'(red_cnt) + 32'(green_cnt) + 32'(none_cnt) + 32'(rows_int)
                                 + 32'(equal_cnt) + 32'(shape), 32'd0);
        CAM_vsync = 1'b1;
        tick;
        tick;
        CAM_vsync = 1'b0;
        tick;
    endtask

    task automatic end_frame(input string t);
        CAM_vsync = 1'b1;
        tick;
        for (int i = 0; i < 20 && !done; i++) tick;
        CAM_vsync = 1'b0;
        check({t, "_done"}, 32'(done), 32'd1);
        check({t, "_busy_end"}, 32'(busy), 32'd0);
        tick;
    endtask

    task automatic expect_frame(input string t, input int r, input int g, input int b, input int n,
                                input int wi, input int na, input int eq, input int ri, input int sh);
        check({t, "_red"},      32'(red_cnt),      r);
        check({t, "_green"},    32'(green_cnt),    g);
        check({t, "_blue"},     32'(blue_cnt),     b);
        check({t, "_none"},     32'(none_cnt),     n);
        check({t, "_wider"},    32'(wider_cnt),    wi);
        check({t, "_narrower"}, 32'(narrower_cnt), na);
        check({t, "_equal"},    32'(equal_cnt),    eq);
        check({t, "_rows_int"}, 32'(rows_int),     ri);
        check({t, "_shape"},    32'(shape),        sh);
    endtask

    task automatic expect_zero(input string t);
        check({t, "_busy"}, 32'(busy), 32'd0);
        check({t, "_done"}, 32'(done), 32'd0);
        expect_frame(t, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int circ_w[5] = '{4, 8, 12, 8, 4};
    int recov_w[3] = '{6, 7, 6};

    initial begin
        CAM_reset   = 1'b1;
        start       = 1'b0;
        CAM_vsync   = 1'b0;
        CAM_href    = 1'b0;
        CAM_px_data = 8'h00;
        tick;
        tick;
        expect_zero("rst");
        CAM_reset = 1'b0;
        tick;

        // 10 x 20 solid red
        begin_frame("red");
        for (int r = 0; r < 10; r++) send_row(run_mask(20, 0), 20, 12'hF00);
        end_frame("red");
        expect_frame("red", 200, 0, 0, 0, 0, 0, 9, 10, 1);
        repeat (3) tick;
        check("red_done_hold", 32'(done), 32'd1);

        // green staircase, with a start mid-frame that must be ignored
        begin_frame("stair");
        for (int r = 1; r <= 10; r++) begin
            send_row(run_mask(2 * r, 0), 20, 12'h0F0);
            if (r == 5) begin
                start = 1'b1;
                tick;
                start = 1'b0;
            end
        end
        end_frame("stair");
        expect_frame("stair", 0, 110, 0, 90, 8, 0, 0, 9, 2);

        // centred blue diamond
        begin_frame("circ");
        for (int r = 0; r < 5; r++) send_row(run_mask(circ_w[r], (16 - circ_w[r]) / 2), 16, 12'h00F);
        end_frame("circ");
        expect_frame("circ", 0, 0, 36, 44, 2, 2, 0, 5, 3);

        // object, four blank rows, then a second object that must be ignored
        begin_frame("close");
        for (int r = 0; r < 4; r++) send_row(run_mask(8, 2), 12, 12'hF00);
        for (int r = 0; r < 4; r++) send_row(32'd0, 12, 12'hF00);
        for (int r = 0; r < 3; r++) send_row(run_mask(12, 0), 12, 12'hF00);
        end_frame("close");
        expect_frame("close", 68, 0, 0, 64, 0, 0, 3, 4, 1);

        // single weak gap inside a run, then a solid row of the expected width 7
        begin_frame("gap");
        send_row(32'h0000_00EF, 8, 12'h0F0);
        send_row(run_mask(7, 0), 7, 12'h0F0);
        end_frame("gap");
        expect_frame("gap", 0, 14, 0, 1, 0, 0, 1, 2, 1);

        // reset mid-frame, then a clean capture with widths inside the tolerance
        begin_frame("mid");
        send_row(run_mask(8, 0), 8, 12'hF00);
        send_row(run_mask(8, 0), 8, 12'hF00);
        CAM_reset = 1'b1;
        #2;
        expect_zero("midrst");
        tick;
        CAM_reset = 1'b0;
        tick;
        check("midrst_idle_busy", 32'(busy), 32'd0);
        begin_frame("recov");
        for (int r = 0; r < 3; r++) send_row(run_mask(recov_w[r], 0), 8, 12'hF00);
        end_frame("recov");
        expect_frame("recov", 19, 0, 0, 5, 0, 0, 2, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
